// File: rtl/uart_tx_fifo_if.sv
// Handshake between the send sequencer (master, clk domain) and the UART transmitter.
// tx_ready is produced in the transmitter's clock domain and is asynchronous to the master.
interface uart_tx_fifo_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] tx_data;
  logic                 tx_write_en;
  logic                 tx_send_en;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_write_en,
    output tx_send_en,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_write_en,
    input  tx_send_en,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular word FIFO feeding a UART transmitter, plus a Moore sequencer that loads and
// sends one word at a time, paced by the transmitter's synchronized ready flag.
//
//  state | meaning
//  IDLE  | waiting for a stored word and transmitter ready
//  LOAD  | tx_write_en pulse, FIFO head popped
//  SEND  | tx_send_en held until ready drops or the send timer expires
//  BUSY  | transmitter busy, waiting for ready to return
module uart_tx_fifo #(
  parameter int WORD_SIZE    = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int SEND_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [WORD_SIZE-1:0]  wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  clear_err,
  uart_tx_fifo_if.master        tx,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW    = $clog2(SEND_TIMEOUT + 1);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [TW-1:0]         TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]         TIMER_MAX = TW'(SEND_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, BUSY} state_t;

  state_t                 state, state_next;
  logic                   rdy_meta, rdy_s;
  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]    count_next;
  logic [TW-1:0]          timer;
  logic                   pop, wr_ok, ovf_set, tmo_set;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= tx.tx_ready;
      rdy_s    <= rdy_meta;
    end
  end

  // A write into a full FIFO is only accepted when the same cycle pops the head.
  assign pop     = (state == LOAD);
  assign wr_ok   = wr_en && !flush && (!fifo_full || pop);
  assign ovf_set = wr_en && !flush && fifo_full && !pop;
  assign tmo_set = (state == SEND) && rdy_s && (timer == TIMER_MAX);

  always_comb begin
    count_next = fifo_count;
    if (flush)
      count_next = '0;
    else if (wr_ok && !pop)
      count_next = fifo_count + CNT_ONE;
    else if (pop && !wr_ok)
      count_next = fifo_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_count <= count_next;
      fifo_full  <= (count_next == CNT_FULL);
      fifo_empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (tmo_set)        timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) timer <= '0;
    else if (state == SEND) timer <= timer + TIMER_ONE;
    else timer <= '0;
  end

  // Head is captured on entry to LOAD so tx_data is valid during the write pulse and
  // a same-cycle write into the slot being popped cannot disturb it.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)
      tx.tx_data <= '0;
    else if (state == IDLE && state_next == LOAD)
      tx.tx_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (!fifo_empty && rdy_s) state_next = LOAD;
        LOAD: state_next = SEND;
        SEND: begin
          if (!rdy_s) state_next = BUSY;
          else if (timer == TIMER_MAX) state_next = IDLE;
        end
        BUSY: if (rdy_s) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tx.tx_write_en = (state == LOAD);
    tx.tx_send_en  = (state == SEND);
  end

endmodule
